interval_timer_master: RTL

Avalon-MM master that drives the 16-bit interval-timer slave register map (status, control, period L/H, snap L/H) from a simple command port, with no CPU involvement. It programs period and mode, starts and stops the timer, and captures counter snapshots. It also services the timer `irq` by clearing the status register and emitting a one-cycle `tick`. It sits between the motion-sequencing logic and the interval-timer instance on the same clock.

---
 rtl/interval_timer_pkg.sv | 23 ++
 rtl/interval_timer_tick_counter.sv | 26 ++
 rtl/interval_timer_master.sv | 115 +++++++++++
 3 files changed

// File: rtl/interval_timer_pkg.sv
// interval_timer_pkg: register map, control bits, command encoding and FSM states
// shared by the interval-timer master and its sub-module.
package interval_timer_pkg;

    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;
    localparam logic [2:0] SNAPL   = 3'd4;
    localparam logic [2:0] SNAPH   = 3'd5;

    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    typedef enum logic [1:0] {OP_START, OP_STOP, OP_SNAP, OP_CLEAR} cmd_op_t;

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, WR_SNAP, RD_SL, RD_SH, CAP_SH, WR_CLR
    } state_t;

endpackage

// File: rtl/interval_timer_tick_counter.sv
// interval_timer_tick_counter: counts serviced timeouts, wrapping at 2^CNT_W.
// Ports: clk, reset_n (async, active-low), tick (count enable), count (CNT_W).
// Built only when INTERVAL_TIMER_MASTER_TICK_COUNT_EN is defined; otherwise
// count is tied to zero and no flops exist.
module interval_timer_tick_counter
    import interval_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             tick,
    output logic [CNT_W-1:0] count
);

`ifdef INTERVAL_TIMER_MASTER_TICK_COUNT_EN
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)  count <= '0;
        else if (tick) count <= count + CNT_W'(1);
`else
    logic unused;
    assign unused = &{1'b0, clk, reset_n, tick};
    assign count  = '0;
`endif

endmodule

// File: rtl/interval_timer_master.sv
// interval_timer_master: Avalon-MM master that programs, starts, stops and snapshots
// a 16-bit interval-timer slave from a command port, and services its irq.
// Ports:
//   clk, reset_n (async, active-low)
//   cmd_valid/cmd_ready/cmd_op/cmd_period/cmd_continuous : command handshake
//   cmd_done, snap_value/snap_valid, tick, tick_count     : results
//   avm_address/avm_chipselect/avm_write_n/avm_writedata/avm_readdata, irq : timer bus
// Optional: INTERVAL_TIMER_MASTER_TICK_COUNT_EN builds the tick_count counter.
module interval_timer_master
    import interval_timer_pkg::*;
#(
    parameter bit IRQ_AUTO = 1'b1,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [31:0]      cmd_period,
    input  logic             cmd_continuous,
    output logic             cmd_done,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [2:0]       avm_address,
    output logic             avm_chipselect,
    output logic             avm_write_n,
    output logic [15:0]      avm_writedata,
    input  logic [15:0]      avm_readdata,
    input  logic             irq
);

    state_t      state, state_nx;
    logic [31:0] period_q;
    logic        cont_q;
    logic        svc_q;
    logic        irq_take;
    logic        accept;
    logic [15:0] ctl_word;

    assign irq_take  = IRQ_AUTO && irq;
    assign cmd_ready = (state == IDLE) && !irq_take;
    assign accept    = cmd_valid && cmd_ready;
    assign ctl_word  = (16'b1 << START) | (16'b1 << ITO) | (16'(cont_q) << CONT);

    // irq wins over a pending command; the command simply waits in IDLE.
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = irq_take            ? WR_CLR  :
                                !cmd_valid          ? IDLE    :
                                cmd_op == OP_START  ? WR_PL   :
                                cmd_op == OP_STOP   ? WR_STOP :
                                cmd_op == OP_SNAP   ? WR_SNAP : WR_CLR;
            WR_PL:   state_nx = WR_PH;
            WR_PH:   state_nx = WR_CTL;
            WR_SNAP: state_nx = RD_SL;
            RD_SL:   state_nx = RD_SH;
            RD_SH:   state_nx = CAP_SH;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        avm_chipselect = !(state inside {IDLE, CAP_SH});
        avm_write_n    = !(state inside {WR_PL, WR_PH, WR_CTL, WR_STOP, WR_SNAP, WR_CLR});
        avm_address    = STATUS;
        avm_writedata  = '0;
        case (state)
            WR_PL:   begin avm_address = PERIODL; avm_writedata = period_q[15:0];  end
            WR_PH:   begin avm_address = PERIODH; avm_writedata = period_q[31:16]; end
            WR_CTL:  begin avm_address = CONTROL; avm_writedata = ctl_word;        end
            WR_STOP: begin avm_address = CONTROL; avm_writedata = 16'b1 << STOP;   end
            WR_SNAP, RD_SL: avm_address = SNAPL;
            RD_SH:   avm_address = SNAPH;
            default: ;
        endcase
    end

    // Slave readdata lags the address by one cycle, so each snapshot half is
    // captured in the state after its read address was presented.
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state      <= IDLE;
            period_q   <= '0;
            cont_q     <= 1'b0;
            svc_q      <= 1'b0;
            snap_value <= '0;
            snap_valid <= 1'b0;
            cmd_done   <= 1'b0;
            tick       <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                period_q <= cmd_period;
                cont_q   <= cmd_continuous;
            end
            if (state == IDLE)   svc_q             <= irq_take;
            if (state == RD_SH)  snap_value[15:0]  <= avm_readdata;
            if (state == CAP_SH) snap_value[31:16] <= avm_readdata;
            cmd_done   <= (state inside {WR_CTL, WR_STOP, CAP_SH}) || (state == WR_CLR && !svc_q);
            snap_valid <= state == CAP_SH;
            tick       <= state == WR_CLR && svc_q;
        end

    interval_timer_tick_counter #(.CNT_W(CNT_W)) u_tick_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick),
        .count   (tick_count)
    );

endmodule
